// File: rtl/shutdown_pkg.sv
// Shared constants for the power-button shutdown sequencer.
// Holds the state encoding and default timing values.
// Imported by the sequencer top.
package shutdown_pkg;

  localparam int STATE_W = 3;

  localparam int DEF_CNT_WIDTH = 24;
  localparam int DEF_LONG_CYC  = 12000000;
  localparam int DEF_ACK_TMO   = 5000000;
  localparam int DEF_DRAIN_CYC = 1000000;
  localparam int DEF_PWRUP_TMO = 2000000;

  typedef enum logic [STATE_W-1:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_RUN   = 3'd2,
    S_HOLD  = 3'd3,
    S_REQ   = 3'd4,
    S_DRAIN = 3'd5,
    S_FAULT = 3'd6
  } state_t;

endpackage

// File: rtl/shutdown_sequencer.sv
// Sequences board power from the debounced button: short press powers up, long press runs a graceful shutdown.
// Latency: transitions on the sampling edge; level outputs and pulses are valid the cycle after that edge.
// Backpressure: none; the host paces shutdown through shutdown_ack, bounded by the ack timeout.
module shutdown_sequencer
  import shutdown_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int LONG_CYC  = DEF_LONG_CYC,
  parameter int ACK_TMO   = DEF_ACK_TMO,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC,
  parameter int PWRUP_TMO = DEF_PWRUP_TMO
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_clean,
  input  logic               pwr_good,
  input  logic               shutdown_ack,
  output logic               pwr_en,
  output logic               shutdown_req,
  output logic               fault,
  output logic               short_press,
  output logic               ack_timeout,
  output logic [STATE_W-1:0] state
);

  // Terminal counts: each wait exits on the edge that sees cnt at PARAM-1.
  localparam logic [CNT_WIDTH-1:0] LONG_LAST  = CNT_WIDTH'(LONG_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] ACK_LAST   = CNT_WIDTH'(ACK_TMO - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(DRAIN_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] PWRUP_LAST = CNT_WIDTH'(PWRUP_TMO - 1);

  state_t                cur_st;
  state_t                nxt_st;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  btn_d;
  logic                  rise;
  logic                  set_sp;
  logic                  set_at;
  logic                  cnt_run;

  // A press only counts when the previous sample was low, so a held button never re-triggers.
  assign rise    = btn_clean & ~btn_d;
  assign cnt_run = (cur_st inside {S_PWRUP, S_HOLD, S_REQ, S_DRAIN});

  // Next-state decode; power-good loss is checked first so it beats button and ack events.
  always_comb begin
    nxt_st = cur_st;
    set_sp = 1'b0;
    set_at = 1'b0;
    case (cur_st)
      S_OFF: begin
        if (rise) nxt_st = S_PWRUP;
      end
      S_PWRUP: begin
        if (pwr_good)                nxt_st = S_RUN;
        else if (cnt == PWRUP_LAST)  nxt_st = S_FAULT;
      end
      S_RUN: begin
        if (!pwr_good)  nxt_st = S_FAULT;
        else if (rise)  nxt_st = S_HOLD;
      end
      S_HOLD: begin
        if (!pwr_good) begin
          nxt_st = S_FAULT;
        end else if (!btn_clean) begin
          nxt_st = S_RUN;
          set_sp = 1'b1;
        end else if (cnt == LONG_LAST) begin
          nxt_st = S_REQ;
        end
      end
      S_REQ: begin
        // An ack arriving on the timeout cycle still counts as a clean ack.
        if (!pwr_good) begin
          nxt_st = S_FAULT;
        end else if (shutdown_ack) begin
          nxt_st = S_DRAIN;
        end else if (cnt == ACK_LAST) begin
          nxt_st = S_DRAIN;
          set_at = 1'b1;
        end
      end
      S_DRAIN: begin
        // Rail stays up for the full drain regardless of pwr_good or the button.
        if (cnt == DRAIN_LAST) nxt_st = S_OFF;
      end
      S_FAULT: begin
        if (rise) nxt_st = S_OFF;
      end
      default: nxt_st = S_OFF;
    endcase
  end

  // State, shared counter, button history and one-cycle pulses; reset drops the rail at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_st      <= S_OFF;
      cnt         <= '0;
      btn_d       <= 1'b0;
      short_press <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      btn_d       <= btn_clean;
      cur_st      <= nxt_st;
      short_press <= set_sp;
      ack_timeout <= set_at;
      if (nxt_st != cur_st)  cnt <= '0;
      else if (cnt_run)      cnt <= cnt + 1'b1;
    end
  end

  // Moore decode straight from the state register.
  assign pwr_en       = (cur_st inside {S_PWRUP, S_RUN, S_HOLD, S_REQ, S_DRAIN});
  assign shutdown_req = (cur_st == S_REQ);
  assign fault        = (cur_st == S_FAULT);
  assign state        = cur_st;

endmodule

// File: tb/tb_shutdown_sequencer.sv
// Directed bench for the shutdown sequencer with a scoreboard of per-cycle expectations.
// Each step drives inputs, queues the state expected after the next edge, then compares #1 after it.
// Timing values are shrunk so every wait runs to completion.
module tb_shutdown_sequencer;
  import shutdown_pkg::*;

  localparam int LONG  = 8;
  localparam int ACK   = 16;
  localparam int DRAIN = 4;
  localparam int PWRUP = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               btn_clean;
  logic               pwr_good;
  logic               shutdown_ack;
  logic               pwr_en;
  logic               shutdown_req;
  logic               fault;
  logic               short_press;
  logic               ack_timeout;
  logic [STATE_W-1:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       pe;
    logic       sr;
    logic       f;
    logic       sp;
    logic       at;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    checks = 0;
  int    passes = 0;
  int    fails  = 0;

  shutdown_sequencer #(
    .CNT_WIDTH(24),
    .LONG_CYC (LONG),
    .ACK_TMO  (ACK),
    .DRAIN_CYC(DRAIN),
    .PWRUP_TMO(PWRUP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_clean   (btn_clean),
    .pwr_good    (pwr_good),
    .shutdown_ack(shutdown_ack),
    .pwr_en      (pwr_en),
    .shutdown_req(shutdown_req),
    .fault       (fault),
    .short_press (short_press),
    .ack_timeout (ack_timeout),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Expected outputs for a given state: rail up from PWRUP through DRAIN, req in REQ, fault in FAULT.
  function automatic exp_t mk(input logic [2:0] s, input logic sp, input logic at);
    exp_t e;
    e.st = s;
    e.pe = (s == 3'd1) || (s == 3'd2) || (s == 3'd3) || (s == 3'd4) || (s == 3'd5);
    e.sr = (s == 3'd4);
    e.f  = (s == 3'd6);
    e.sp = sp;
    e.at = at;
    return e;
  endfunction

  task automatic push_exp(input exp_t e, input string tag);
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  task automatic chk(input string tag, input string what, input logic [2:0] got, input logic [2:0] want);
    checks++;
    assert (got === want) passes++;
    else begin
      fails++;
      $error("FAIL %s.%s got=%0d expected=%0d", tag, what, got, want);
    end
  endtask

  task automatic compare();
    exp_t  e;
    string t;
    checks++;
    assert (sb.size() != 0) passes++;
    else begin
      fails++;
      $error("FAIL scoreboard got=empty expected=entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      t = tags.pop_front();
      chk(t, "state",        state,                  e.st);
      chk(t, "pwr_en",       {2'b00, pwr_en},        {2'b00, e.pe});
      chk(t, "shutdown_req", {2'b00, shutdown_req},  {2'b00, e.sr});
      chk(t, "fault",        {2'b00, fault},         {2'b00, e.f});
      chk(t, "short_press",  {2'b00, short_press},   {2'b00, e.sp});
      chk(t, "ack_timeout",  {2'b00, ack_timeout},   {2'b00, e.at});
    end
  endtask

  task automatic step(input logic b, input logic pg, input logic ak,
                      input logic [2:0] s, input logic sp, input logic at, input string tag);
    btn_clean    = b;
    pwr_good     = pg;
    shutdown_ack = ak;
    push_exp(mk(s, sp, at), tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic run(input int n, input logic b, input logic pg, input logic ak,
                     input logic [2:0] s, input string tag);
    for (int i = 0; i < n; i++) step(b, pg, ak, s, 1'b0, 1'b0, tag);
  endtask

  initial begin
    rst          = 1'b1;
    btn_clean    = 1'b0;
    pwr_good     = 1'b0;
    shutdown_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push_exp(mk(3'd0, 1'b0, 1'b0), "reset");
    compare();
    rst = 1'b0;

    // Power-up: rise enters PWRUP on its first sampling edge, pwr_good two cycles later.
    step(1, 0, 0, 3'd1, 0, 0, "pu_rise");
    step(1, 0, 0, 3'd1, 0, 0, "pu_wait");
    step(1, 1, 0, 3'd2, 0, 0, "pu_good");
    step(0, 1, 0, 3'd2, 0, 0, "run_idle");

    // Short press: five cycles in HOLD, release pulses short_press once.
    run(5, 1, 1, 0, 3'd1 + 3'd2, "sp_hold");
    step(0, 1, 0, 3'd2, 1, 0, "sp_release");
    step(0, 1, 0, 3'd2, 0, 0, "sp_after");

    // Long press: REQ entered LONG edges after HOLD entry, then ack and drain.
    run(LONG, 1, 1, 0, 3'd3, "lp_hold");
    step(1, 1, 0, 3'd4, 0, 0, "lp_req");
    run(5, 0, 1, 0, 3'd4, "req_wait");
    step(0, 1, 1, 3'd5, 0, 0, "ack_drain");
    run(DRAIN - 1, 0, 1, 1, 3'd5, "drain");
    step(0, 1, 0, 3'd0, 0, 0, "drain_off");
    step(0, 0, 0, 3'd0, 0, 0, "off_idle");

    // Ack timeout: REQ visible for ACK cycles, pulse on the forced exit.
    step(1, 0, 0, 3'd1, 0, 0, "to_rise");
    step(0, 1, 0, 3'd2, 0, 0, "to_good");
    run(LONG, 1, 1, 0, 3'd3, "to_hold");
    step(1, 1, 0, 3'd4, 0, 0, "to_req");
    run(ACK - 1, 0, 1, 0, 3'd4, "to_wait");
    step(0, 1, 0, 3'd5, 0, 1, "to_fire");
    run(DRAIN - 1, 0, 1, 0, 3'd5, "to_drain");
    step(0, 1, 0, 3'd0, 0, 0, "to_off");

    // Power-up fault: pwr_good never comes, FAULT after PWRUP cycles; held button needs re-press.
    step(1, 0, 0, 3'd1, 0, 0, "pf_rise");
    run(PWRUP - 1, 0, 0, 0, 3'd1, "pf_wait");
    step(0, 0, 0, 3'd6, 0, 0, "pf_fault");
    step(1, 0, 0, 3'd0, 0, 0, "pf_clear");
    run(2, 1, 0, 0, 3'd0, "pf_held");
    step(0, 0, 0, 3'd0, 0, 0, "pf_release");

    // pwr_good loss in REQ beats a simultaneous ack.
    step(1, 0, 0, 3'd1, 0, 0, "pg_rise");
    step(0, 1, 0, 3'd2, 0, 0, "pg_good");
    run(LONG, 1, 1, 0, 3'd3, "pg_hold");
    step(1, 1, 0, 3'd4, 0, 0, "pg_req");
    run(2, 0, 1, 0, 3'd4, "pg_wait");
    step(0, 0, 1, 3'd6, 0, 0, "pg_drop");
    step(1, 0, 0, 3'd0, 0, 0, "pg_clear");
    step(1, 0, 0, 3'd0, 0, 0, "pg_held");
    step(0, 0, 0, 3'd0, 0, 0, "pg_release");

    // Ack on the timeout cycle wins without a pulse; button held throughout.
    step(1, 0, 0, 3'd1, 0, 0, "at_rise");
    step(1, 1, 0, 3'd2, 0, 0, "at_good");
    step(0, 1, 0, 3'd2, 0, 0, "at_release");
    run(LONG, 1, 1, 0, 3'd3, "at_hold");
    step(1, 1, 0, 3'd4, 0, 0, "at_req");
    run(ACK - 1, 1, 1, 0, 3'd4, "at_wait");
    step(1, 1, 1, 3'd5, 0, 0, "at_ack_on_tmo");
    step(1, 1, 1, 3'd5, 0, 0, "at_drain");

    // Asynchronous reset between edges mid-drain: rail drops with no edge.
    #2;
    rst = 1'b1;
    #1;
    push_exp(mk(3'd0, 1'b0, 1'b0), "async_rst");
    compare();
    btn_clean    = 1'b0;
    shutdown_ack = 1'b0;
    @(posedge clk);
    #1;
    push_exp(mk(3'd0, 1'b0, 1'b0), "rst_hold");
    compare();
    rst = 1'b0;
    run(2, 0, 1, 0, 3'd0, "post_rst");
    step(1, 0, 0, 3'd1, 0, 0, "repress");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
